hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Producer-side partner of the EX-stage forwarding unit: tracks in-flight destination registers whose results are not yet
//  on a forwarding path (loads, multi-cycle MUL/DIV) and stalls the ID stage on RAW/WAW hazards until forwarding can
//  cover them. Sits beside ID; its stall drives PC/IF-ID hold and an EX bubble. ALU ops (latency 0) are never tracked.
// PARAMETERS
//  REG_ADDR_W  6   register index width (matches the 6-bit rs/rd fields used by forwarding)
//  NUM_REGS    64  tracked entries, = 2**REG_ADDR_W
//  MAX_LAT     7   largest latency class; id_lat values above it saturate to MAX_LAT
//  LAT_W       3   width of id_lat and of each entry countdown, >= clog2(MAX_LAT+1)
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           synchronous, active-high reset
//  id_rs1         in   REG_ADDR_W  source 1 of instruction in ID
//  id_rs2         in   REG_ADDR_W  source 2 of instruction in ID
//  id_rs1_used    in   1           instruction actually reads rs1
//  id_rs2_used    in   1           instruction actually reads rs2
//  id_rd          in   REG_ADDR_W  destination of instruction in ID
//  id_regs_write  in   1           instruction writes id_rd
//  id_lat         in   LAT_W       cycles until result reaches a forwarding path (0=ALU, 1=load, 3=MUL, 7=DIV)
//  id_issue       in   1           instruction leaves ID into EX this cycle (gated internally by ~stall)
//  id_flush       in   1           ID instruction killed this cycle; suppresses issue and stall
//  wb_rd          in   REG_ADDR_W  writeback destination
//  wb_regs_write  in   1           writeback valid
//  stall          out  1           hold PC and IF/ID, inject EX bubble
//  stall_raw      out  1           stall cause: source operand not yet forwardable
//  stall_waw      out  1           stall cause: earlier producer of id_rd still counting down
//  busy_vec       out  NUM_REGS    pending bit per register (debug / trace)
//  stall_cycles   out  32          stall cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Entry i: pending bit + LAT_W countdown. Reset: all pending=0, count=0 -> stall/stall_raw/stall_waw=0, busy_vec=0.
//  - Accepted issue = id_issue & ~stall & ~id_flush & id_regs_write & (id_rd!=0) & (id_lat!=0): next cycle entry[id_rd]
//    pending=1, count=min(id_lat,MAX_LAT). Entry 0 never set.
//  - Every cycle each nonzero count decrements by 1, saturating at 0; count=0 with pending=1 means forwardable.
//  - Writeback: wb_regs_write & wb_rd!=0 clears pending of entry[wb_rd] (count is already 0 by then).
//  - Same-cycle accepted issue and writeback on the same register: issue wins (new producer, entry reloaded).
//  - stall_raw = (rs1_used & rs1!=0 & count[rs1]!=0) | (rs2_used & rs2!=0 & count[rs2]!=0).
//  - stall_waw = id_regs_write & id_rd!=0 & count[id_rd] > id_lat (keeps in-order writeback).
//  - stall = (stall_raw | stall_waw) & ~id_flush; purely combinational from registered state + ID inputs, 0-cycle latency.
//  - Load-use: load issued cycle t -> dependent in ID at t+1 stalls exactly 1 cycle, issues at t+2.
//  - id_issue asserted while stall=1 is ignored (no entry update).
//  - Reset mid-operation clears every entry on the next edge regardless of other inputs.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cycles = 32-bit counter, reset to 0, +1 every cycle stall=1, wraps at 2^32-1 -> 0.
//  Not defined: stall_cycles tied to 32'd0, no counter flops synthesized.
// STRUCTURE
//  define.vh (shared header): latency-class constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3, LAT_DIV=7, and REG_ADDR_W.
//  Sub-module sb_entry: one pending bit + countdown with load/decrement/clear; instanced NUM_REGS-1 times (x0 constant 0).
//  Top: generate loop of sb_entry, source/dest read muxes, stall logic, optional perf counter.
// TESTING
//  1 Load-use: issue rd=5 lat=1 at t; t+1 ID rs1=5 used -> stall=1,stall_raw=1 one cycle; t+2 stall=0.
//  2 x0/unused: issue rd=0 lat=3, then rs1=0 -> stall=0, busy_vec=0; rs2=5 with rs2_used=0 after load to 5 -> stall=0.
//  3 DIV then MUL WAW: DIV rd=7 lat=7 issued, next cycle MUL rd=7 lat=3 -> stall_waw=1 until count[7]<=3, then issue.
//  4 Same-cycle issue+WB on rd=9 (lat=3) -> busy_vec[9]=1, count[9]=3 next cycle; WB alone on rd=9 later clears bit.
//  5 Flush: dependent in ID with id_flush=1 -> stall=0, id_issue ignored, no entry written.
//  6 Reset with 3 entries counting -> next cycle busy_vec=0, stall=0, stall_cycles=0 (with HAZARD_PERF_CNT_EN).

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard.
// Latency classes mirror the execution units feeding the forwarding paths.
package hazard_scoreboard_pkg;

    localparam int HS_REG_ADDR_W = 6;
    localparam int HS_NUM_REGS   = 2 ** HS_REG_ADDR_W;
    localparam int HS_MAX_LAT    = 7;
    localparam int HS_LAT_W      = 3;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 7;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: pending bit plus result-latency countdown.
// Load beats clear so a new producer replaces a retiring one.
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int LAT_W = HS_LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_lat,
    input  logic             i_clr,
    output logic             o_pending,
    output logic [LAT_W-1:0] o_count
);

    logic             r_pending;
    logic [LAT_W-1:0] r_count;

    // pending bit: set by a new producer, cleared by its writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (i_load) begin
            r_pending <= 1'b1;
        end else if (i_clr) begin
            r_pending <= 1'b0;
        end
    end

    // countdown: reload on issue, otherwise saturating decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_lat;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_pending = r_pending;
    assign o_count   = r_count;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stalls on RAW/WAW against long-latency producers.
// Optional stall cycle counter enabled by HAZARD_PERF_CNT_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = HS_REG_ADDR_W,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W,
    parameter int MAX_LAT    = HS_MAX_LAT,
    parameter int LAT_W      = HS_LAT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regs_write,
    input  logic [LAT_W-1:0]      id_lat,
    input  logic                  id_issue,
    input  logic                  id_flush,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regs_write,
    output logic                  stall,
    output logic                  stall_raw,
    output logic                  stall_waw,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [31:0]           stall_cycles
);

    logic [LAT_W-1:0]    w_count [NUM_REGS];
    logic [NUM_REGS-1:0] w_pend;
    logic [LAT_W-1:0]    w_lat_sat;
    logic [LAT_W-1:0]    w_cnt_rs1;
    logic [LAT_W-1:0]    w_cnt_rs2;
    logic [LAT_W-1:0]    w_cnt_rd;
    logic                w_issue;
    logic                w_wb;

    assign w_lat_sat = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;

    assign w_issue = id_issue && !stall && !id_flush && id_regs_write &&
                     (id_rd != '0) && (w_lat_sat != LAT_W'(LAT_ALU));

    assign w_wb = wb_regs_write && (wb_rd != '0);

    // x0 is hardwired: never pending, always forwardable
    assign w_count[0] = '0;
    assign w_pend[0]  = 1'b0;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_ent
        sb_entry #(
            .LAT_W(LAT_W)
        ) u_ent (
            .clk      (clk),
            .rst      (rst),
            .i_load   (w_issue && (id_rd == REG_ADDR_W'(gi))),
            .i_lat    (w_lat_sat),
            .i_clr    (w_wb && (wb_rd == REG_ADDR_W'(gi))),
            .o_pending(w_pend[gi]),
            .o_count  (w_count[gi])
        );
    end

    assign w_cnt_rs1 = w_count[id_rs1];
    assign w_cnt_rs2 = w_count[id_rs2];
    assign w_cnt_rd  = w_count[id_rd];

    assign stall_raw = (id_rs1_used && (id_rs1 != '0) && (w_cnt_rs1 != '0)) ||
                       (id_rs2_used && (id_rs2 != '0) && (w_cnt_rs2 != '0));

    // older producer still further out would write back after us
    assign stall_waw = id_regs_write && (id_rd != '0) && (w_cnt_rd > w_lat_sat);

    assign stall    = (stall_raw || stall_waw) && !id_flush;
    assign busy_vec = w_pend;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    // count every cycle the front end is held; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed scenarios then random traffic.
// Reference model tracks per-register ready cycle instead of countdowns.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_rs1_used, id_rs2_used, id_regs_write;
    logic [2:0]  id_lat;
    logic        id_issue, id_flush, wb_regs_write;
    logic        stall, stall_raw, stall_waw;
    logic [63:0] busy_vec;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_regs_write(id_regs_write),
        .id_lat       (id_lat),
        .id_issue     (id_issue),
        .id_flush     (id_flush),
        .wb_rd        (wb_rd),
        .wb_regs_write(wb_regs_write),
        .stall        (stall),
        .stall_raw    (stall_raw),
        .stall_waw    (stall_waw),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        logic [2:0]  causes;
        logic [63:0] busy;
        logic [31:0] sc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   passes = 0;
    int   total  = 0;
    int   pops   = 0;
    int   pushes = 0;

    // reference state: cycle at which each register's result is forwardable
    int          cyc = 0;
    int          ready_at [64];
    bit          pend [64];
    logic [31:0] perf = 0;
    bit          exp_stall;

    function automatic int cnt_of(input logic [5:0] r);
        if (r == 0) return 0;
        return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
    endfunction

    task automatic chk(input string nm, input int c,
                       input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passes++;
        else $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, req);
    endtask

    // monitor: compare DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            pops++;
            chk("stall/raw/waw", e.cyc, {61'd0, stall, stall_raw, stall_waw},
                {61'd0, e.causes});
            chk("busy_vec", e.cyc, busy_vec, e.busy);
            chk("stall_cycles", e.cyc, {32'd0, stall_cycles}, {32'd0, e.sc});
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            ready_at[i] = 0;
            pend[i] = 0;
        end
        perf = 0;
    endtask

    // predict this cycle's outputs, let the edge happen, then advance the model
    task automatic step();
        exp_t e;
        bit raw, waw;
        int lat;
        lat = (id_lat > 7) ? 7 : int'(id_lat);
        raw = (id_rs1_used && id_rs1 != 0 && cnt_of(id_rs1) != 0) ||
              (id_rs2_used && id_rs2 != 0 && cnt_of(id_rs2) != 0);
        waw = id_regs_write && id_rd != 0 && cnt_of(id_rd) > lat;
        exp_stall = (raw || waw) && !id_flush;
        e.causes = {exp_stall, raw, waw};
        for (int i = 0; i < 64; i++) e.busy[i] = pend[i];
`ifdef HAZARD_PERF_CNT_EN
        e.sc = perf;
`else
        e.sc = 32'd0;
`endif
        e.cyc = cyc;
        q.push_back(e);
        pushes++;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (exp_stall) perf = perf + 1;
            if (wb_regs_write && wb_rd != 0) pend[wb_rd] = 0;
            if (id_issue && !exp_stall && !id_flush && id_regs_write &&
                id_rd != 0 && lat != 0) begin
                pend[id_rd] = 1;
                ready_at[id_rd] = cyc + 1 + lat;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_regs_write = 0; id_lat = 0; id_issue = 0;
        id_flush = 0; wb_rd = 0; wb_regs_write = 0;
    endtask

    task automatic prod(input logic [5:0] rd, input logic [2:0] lat);
        idle();
        id_rd = rd; id_regs_write = 1; id_lat = lat; id_issue = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        model_clear();
        step();
        rst = 0;
        step();

        // load-use
        prod(5, 1); step();
        idle(); id_rs1 = 5; id_rs1_used = 1; id_issue = 1; step();
        step();

        // x0 destination and unused source
        prod(0, 3); step();
        idle(); id_rs1 = 0; id_rs1_used = 1; id_issue = 1; step();
        prod(5, 1); step();
        idle(); id_rs2 = 5; id_rs2_used = 0; id_issue = 1; step();

        // DIV then MUL to the same register
        prod(7, 7); step();
        prod(7, 3);
        for (int i = 0; i < 6; i++) step();

        // same-cycle issue and writeback, then lone writeback
        prod(9, 3); wb_rd = 9; wb_regs_write = 1; step();
        idle(); for (int i = 0; i < 4; i++) step();
        wb_rd = 9; wb_regs_write = 1; step();
        idle(); step();

        // flush of a dependent that would also produce
        prod(4, 1); step();
        prod(10, 3); id_rs1 = 4; id_rs1_used = 1; id_flush = 1; step();
        idle(); step();

        // reset with entries counting
        prod(11, 7); step();
        prod(12, 3); step();
        prod(13, 7); step();
        idle(); id_rs1 = 11; id_rs1_used = 1; step();
        rst = 1; step();
        rst = 0; idle(); id_rs1 = 11; id_rs1_used = 1; step();

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            id_rs1 = 6'($urandom_range(0, 7));
            id_rs2 = 6'($urandom_range(0, 7));
            id_rd  = 6'($urandom_range(0, 7));
            id_rs1_used   = 1'($urandom_range(0, 1));
            id_rs2_used   = 1'($urandom_range(0, 1));
            id_regs_write = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: id_lat = 3'd0;
                1: id_lat = 3'd1;
                2: id_lat = 3'd3;
                3: id_lat = 3'd7;
                default: id_lat = 3'($urandom_range(0, 7));
            endcase
            id_issue      = ($urandom_range(0, 4) != 0);
            id_flush      = ($urandom_range(0, 9) == 0);
            wb_rd         = 6'($urandom_range(0, 7));
            wb_regs_write = 1'($urandom_range(0, 1));
            rst           = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;
        idle();
        @(negedge clk);
        #1;
        total++;
        if (q.size() == 0 && pops == pushes) passes++;
        else $display("FAIL drain: %0d pending, %0d popped of %0d", q.size(), pops, pushes);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
